if_id_fetch_queue: RTL and testbench
====================================

# if_id_fetch_queue

Parametrised decoupling queue between the IF and ID stages of the Falco core, replacing the fixed two-lane IF/ID bundle. It accepts up to FETCH_WIDTH in-order instructions per cycle and presents up to DISPATCH_WIDTH oldest entries to ID. Each instruction carries its raw word, PC and BHSR snapshot, so fetch and decode stalls are absorbed without dropping instructions. A flush empties the queue on redirect.

## Interface
- FETCH_WIDTH, 2, instructions written per cycle (1..4)
- DISPATCH_WIDTH, 2, instructions presented per cycle (1..4, <= DEPTH)
- DEPTH, 8, entry count; power of two, >= FETCH_WIDTH
- Ports (clock and reset first):
- clk  in  1  core clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  discard all entries (branch/trap redirect)
- fetch_valid_i  in  FETCH_WIDTH  per-lane valid, thermometer (lane 0 oldest)
- fetch_instr_i  in  FETCH_WIDTH x raw_instruction_t  raw instruction words
- fetch_pc_i  in  FETCH_WIDTH x pc_t  lane PCs
- fetch_bhsr_i  in  FETCH_WIDTH x BHSR_t  BHSR at prediction time
- fetch_ready_o  out  1  queue can take FETCH_WIDTH entries this cycle
- id_valid_o  out  DISPATCH_WIDTH  thermometer; lane i valid iff count > i
- id_instr_o / id_pc_o / id_bhsr_o  out  DISPATCH_WIDTH x type  entries head..head+DISPATCH_WIDTH-1
- id_pop_i  in  DISPATCH_WIDTH  thermometer consume mask from ID
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer of fetch_entry_t; registered head, tail (log2 DEPTH bits, wrap modulo DEPTH) and count.
- Push: when fetch_ready_o && !flush_i, n_push = leading-ones count of fetch_valid_i. Lane k is written to tail+k, and tail advances by n_push. Non-contiguous valid bits beyond the first zero are ignored; a simulation assertion flags them.
- Pop: n_pop = leading-ones count of (id_pop_i & id_valid_o). Head advances by n_pop. A pop of an invalid lane is ignored and asserted.
- count_next = count + n_push - n_pop. Width is sufficient for 0..DEPTH, and no under/overflow is possible by construction.
- fetch_ready_o = (count <= DEPTH - FETCH_WIDTH). It is computed from the registered count only; same-cycle pops do not raise it. Push is all-or-nothing capacity: a partial push still needs full FETCH_WIDTH space.
- id_* outputs read combinationally from storage at head+i (mod DEPTH). Lanes with i >= count drive id_valid_o[i]=0; their data is don't-care.
- Flush: at the next edge head=tail=count=0. Same-cycle push and pop are discarded. Storage contents are not cleared.
- Simultaneous push+pop on a full-minus-partial queue: both take effect, using the pre-pop count for the ready decision.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): head=tail=count=0, id_valid_o=0, count_o=0, fetch_ready_o=1.
- Reset mid-operation: all entries lost immediately; outputs reach reset values without a clock edge.
- Push-to-visible latency is 1 cycle: written at edge t, id_valid_o is set after edge t. There is no same-cycle bypass.
- Pop takes effect at the edge of the cycle id_pop_i is sampled. The next entries appear on id_* after that edge.
- Flush-to-empty is 1 edge. fetch_ready_o is 1 the cycle after a flush.
- Back-to-back: sustained FETCH_WIDTH in / DISPATCH_WIDTH out per cycle with no bubbles when count stays in range.

## Structure
- Falco_pkg gains:
  - fetch_entry_t (packed struct: raw_instruction_t raw; pc_t pc; BHSR_t bhsr);
  - a lead_ones function for thermometer counting.
- raw_instruction_t, pc_t and BHSR_t are reused unchanged.
- Single module; storage is a fetch_entry_t array with per-lane write enables. No sub-module is required.
- FALCO_SIM_DEBUG adds verilator-public accessors for count and head PC (0xFFFFFFFF when empty).

## Test plan
Configuration: FETCH_WIDTH=2, DISPATCH_WIDTH=2, DEPTH=8.
- Reset, then push {0x00000013 @PC 0x100, 0x00100093 @PC 0x104} with id_pop_i=0 -> next cycle id_valid_o=2'b11, id_pc_o={0x104,0x100}, count_o=2.
- Push 2/cycle for 4 cycles without pops -> count_o=8, fetch_ready_o=0 at count 7 and 8, and the 5th push is not accepted.
- Queue holds 7, push 2 + pop 2 same cycle -> fetch_ready_o=0, so only the pop occurs and count_o=5.
- Wrap: 20 cycles push 2 / pop 2 with incrementing PCs -> output PC order is strictly +4 with no gaps across tail/head wrap.
- Queue holds 5, flush_i with concurrent push and pop -> count_o=0, id_valid_o=0, fetch_ready_o=1 next cycle.
- Queue holds 3 and rst_n is pulled low between edges -> id_valid_o=0 and count_o=0 immediately; after release, the first push appears after 1 cycle.

Source files
------------

// File: rtl/if_id_fetch_queue_pkg.sv
// Shared types for the IF/ID decoupling queue: per-instruction entry layout and
// a thermometer-mask counting helper.
package if_id_fetch_queue_pkg;

  typedef logic [31:0] raw_instruction_t;
  typedef logic [31:0] pc_t;
  typedef logic [7:0]  BHSR_t;

  typedef struct packed {
    raw_instruction_t raw;
    pc_t              pc;
    BHSR_t            bhsr;
  } fetch_entry_t;

  localparam int unsigned MaxLanes = 4;

  // Number of consecutive ones starting at bit 0; bits past the first zero are ignored.
  function automatic logic [2:0] lead_ones(logic [MaxLanes-1:0] v);
    logic [2:0] n;
    logic       run;
    n   = 3'd0;
    run = 1'b1;
    for (int i = 0; i < MaxLanes; i++) begin
      run = run & v[i];
      if (run) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/if_id_fetch_queue.sv
// Circular IF->ID instruction queue: up to FETCH_WIDTH pushes and DISPATCH_WIDTH
// pops per cycle, with flush-on-redirect.
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH    = 2,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned DEPTH          = 8,
  localparam int unsigned PtrW          = $clog2(DEPTH),
  localparam int unsigned CntW          = $clog2(DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush_i,
  input  logic             [FETCH_WIDTH-1:0]     fetch_valid_i,
  input  raw_instruction_t [FETCH_WIDTH-1:0]     fetch_instr_i,
  input  pc_t              [FETCH_WIDTH-1:0]     fetch_pc_i,
  input  BHSR_t            [FETCH_WIDTH-1:0]     fetch_bhsr_i,
  output logic                                   fetch_ready_o,
  output logic             [DISPATCH_WIDTH-1:0]  id_valid_o,
  output raw_instruction_t [DISPATCH_WIDTH-1:0]  id_instr_o,
  output pc_t              [DISPATCH_WIDTH-1:0]  id_pc_o,
  output BHSR_t            [DISPATCH_WIDTH-1:0]  id_bhsr_o,
  input  logic             [DISPATCH_WIDTH-1:0]  id_pop_i,
  output logic             [CntW-1:0]            count_o
);

  fetch_entry_t mem_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic                   push_en;
  logic [CntW-1:0]        n_push;
  logic [CntW-1:0]        n_pop;
  logic [FETCH_WIDTH-1:0] we;

  // Ready depends on registered count only; a same-cycle pop never frees room.
  assign fetch_ready_o = (count_q <= CntW'(DEPTH - FETCH_WIDTH));
  assign push_en       = fetch_ready_o && !flush_i;
  assign count_o       = count_q;

  always_comb begin
    n_push = '0;
    n_pop  = '0;
    we     = '0;
    if (push_en) n_push = CntW'(lead_ones(MaxLanes'(fetch_valid_i)));
    if (!flush_i) n_pop = CntW'(lead_ones(MaxLanes'(id_pop_i & id_valid_o)));
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      we[k] = CntW'(k) < n_push;
    end
  end

  always_comb begin
    head_d  = head_q + PtrW'(n_pop);
    tail_d  = tail_q + PtrW'(n_push);
    count_d = count_q + n_push - n_pop;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (we[k]) begin
        mem_q[tail_q + PtrW'(k)] <= '{raw: fetch_instr_i[k], pc: fetch_pc_i[k],
                                      bhsr: fetch_bhsr_i[k]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      id_valid_o[i] = count_q > CntW'(i);
      id_instr_o[i] = mem_q[head_q + PtrW'(i)].raw;
      id_pc_o[i]    = mem_q[head_q + PtrW'(i)].pc;
      id_bhsr_o[i]  = mem_q[head_q + PtrW'(i)].bhsr;
    end
  end

`ifdef FALCO_SIM_DEBUG
  logic [CntW-1:0] dbg_count;
  pc_t             dbg_head_pc;
  assign dbg_count   = count_q;
  assign dbg_head_pc = (count_q == '0) ? 32'hFFFF_FFFF : mem_q[head_q].pc;
`endif

`ifndef SYNTHESIS
  valid_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
    (fetch_valid_i & (fetch_valid_i + 1'b1)) == '0);
  pop_only_valid: assert property (@(posedge clk) disable iff (!rst_n || flush_i)
    (id_pop_i & ~id_valid_o) == '0);
`endif

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue with FETCH_WIDTH=2, DISPATCH_WIDTH=2, DEPTH=8.
module tb_if_id_fetch_queue;
  import if_id_fetch_queue_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   flush_i;
  logic             [1:0] fetch_valid_i;
  raw_instruction_t [1:0] fetch_instr_i;
  pc_t              [1:0] fetch_pc_i;
  BHSR_t            [1:0] fetch_bhsr_i;
  logic                   fetch_ready_o;
  logic             [1:0] id_valid_o;
  raw_instruction_t [1:0] id_instr_o;
  pc_t              [1:0] id_pc_o;
  BHSR_t            [1:0] id_bhsr_o;
  logic             [1:0] id_pop_i;
  logic             [3:0] count_o;

  int n_checks = 0;
  int n_pass   = 0;

  if_id_fetch_queue #(
    .FETCH_WIDTH   (2),
    .DISPATCH_WIDTH(2),
    .DEPTH         (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_instr_i(fetch_instr_i),
    .fetch_pc_i   (fetch_pc_i),
    .fetch_bhsr_i (fetch_bhsr_i),
    .fetch_ready_o(fetch_ready_o),
    .id_valid_o   (id_valid_o),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_bhsr_o    (id_bhsr_o),
    .id_pop_i     (id_pop_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    fetch_valid_i = 2'b00;
    id_pop_i      = 2'b00;
  endtask

  // Drive a fetch group; instruction word and BHSR are derived from the PC.
  task automatic fetch(input logic [1:0] valid, input pc_t pc0);
    fetch_valid_i    = valid;
    fetch_pc_i[0]    = pc0;
    fetch_pc_i[1]    = pc0 + 32'd4;
    fetch_instr_i[0] = pc0 ^ 32'h0000_0013;
    fetch_instr_i[1] = (pc0 + 32'd4) ^ 32'h0000_0013;
    fetch_bhsr_i[0]  = pc0[9:2];
    fetch_bhsr_i[1]  = 8'(pc0[9:2] + 8'd1);
  endtask

  pc_t exp_pc;

  initial begin
    rst_n = 1'b0;
    idle();
    fetch(2'b00, 32'h0);
    #1;
    check("reset_count", count_o, 0);
    check("reset_valid", id_valid_o, 0);
    check("reset_ready", fetch_ready_o, 1);
    #12 rst_n = 1'b1;
    step();

    // First push with the literal instruction words
    fetch_valid_i    = 2'b11;
    fetch_instr_i[0] = 32'h0000_0013;
    fetch_instr_i[1] = 32'h0010_0093;
    fetch_pc_i[0]    = 32'h100;
    fetch_pc_i[1]    = 32'h104;
    fetch_bhsr_i[0]  = 8'h5A;
    fetch_bhsr_i[1]  = 8'hA5;
    #1 check("no_bypass_valid", id_valid_o, 2'b00);
    step();
    idle();
    check("push1_valid", id_valid_o, 2'b11);
    check("push1_pc0", id_pc_o[0], 32'h100);
    check("push1_pc1", id_pc_o[1], 32'h104);
    check("push1_instr0", id_instr_o[0], 32'h0000_0013);
    check("push1_instr1", id_instr_o[1], 32'h0010_0093);
    check("push1_bhsr1", id_bhsr_o[1], 8'hA5);
    check("push1_count", count_o, 2);

    // Fill to full
    for (int i = 0; i < 3; i++) begin
      fetch(2'b11, 32'h108 + 32'(i * 8));
      step();
      check("fill_count", count_o, 32'(4 + 2 * i));
    end
    idle();
    check("full_ready", fetch_ready_o, 0);
    fetch(2'b11, 32'h120);
    step();
    idle();
    check("full_reject_count", count_o, 8);
    check("full_head_pc", id_pc_o[0], 32'h100);

    flush_i = 1'b1;
    step();
    idle();
    check("flush1_count", count_o, 0);
    check("flush1_ready", fetch_ready_o, 1);

    // Fill to 7, then push+pop in one cycle: only the pop lands
    for (int i = 0; i < 3; i++) begin
      fetch(2'b11, 32'h200 + 32'(i * 8));
      step();
    end
    fetch(2'b01, 32'h218);
    step();
    idle();
    check("seven_count", count_o, 7);
    check("seven_ready", fetch_ready_o, 0);
    fetch(2'b11, 32'h21C);
    id_pop_i = 2'b11;
    step();
    idle();
    check("pushpop7_count", count_o, 5);
    check("pushpop7_head", id_pc_o[0], 32'h208);
    check("pushpop7_lane1", id_pc_o[1], 32'h20C);

    // Holds 5: flush beats concurrent push and pop
    check("pre_flush_ready", fetch_ready_o, 1);
    flush_i = 1'b1;
    fetch(2'b11, 32'h700);
    id_pop_i = 2'b11;
    step();
    idle();
    check("flush2_count", count_o, 0);
    check("flush2_valid", id_valid_o, 0);
    check("flush2_ready", fetch_ready_o, 1);

    // Streaming through several pointer wraps
    fetch(2'b11, 32'h300);
    step();
    exp_pc = 32'h300;
    for (int i = 0; i < 20; i++) begin
      fetch(2'b11, 32'h308 + 32'(i * 8));
      id_pop_i = 2'b11;
      check("wrap_valid", id_valid_o, 2'b11);
      check("wrap_pc0", id_pc_o[0], exp_pc);
      check("wrap_pc1", id_pc_o[1], exp_pc + 32'd4);
      step();
      exp_pc = exp_pc + 32'd8;
    end
    idle();
    check("wrap_count", count_o, 2);
    check("wrap_head", id_pc_o[0], 32'h3A0);
    check("wrap_bhsr", id_bhsr_o[0], 8'hE8);

    // Asynchronous reset between edges with 3 entries held
    fetch(2'b01, 32'h500);
    step();
    idle();
    check("pre_reset_count", count_o, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", id_valid_o, 0);
    check("async_rst_count", count_o, 0);
    check("async_rst_ready", fetch_ready_o, 1);
    #2 rst_n = 1'b1;
    fetch(2'b01, 32'h400);
    #1 check("post_rst_nobypass", id_valid_o, 0);
    step();
    idle();
    check("post_rst_valid", id_valid_o, 2'b01);
    check("post_rst_pc", id_pc_o[0], 32'h400);
    check("post_rst_count", count_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
